// File: rtl/dm_bytelane.sv
// dm_bytelane: word-organised data memory with byte/halfword lane access.
//
// A load or store request is accepted in IDLE, held for LATENCY wait cycles,
// and completes with a single-cycle Ready pulse. Err is raised together with
// Ready when an access is misaligned, has an illegal size code, or lies
// outside the mapped window.
//
// Ports
//   clk      single clock, rising edge
//   reset    synchronous, active-high reset
//   MemAddr  byte address of the request
//   MemData  store data; narrow stores use the low byte/halfword
//   MemWr    store request (wins over MemRd when both are high)
//   MemRd    load request
//   MemOp    size: 000 word, 001 lbu, 010 lb, 011 lhu, 100 lh
//   RegData  extended load result, held between completions
//   Ready    one-cycle completion pulse
//   Err      one-cycle error pulse, coincident with Ready
//
// state | meaning
// IDLE  | waiting for MemWr/MemRd; request latched on acceptance
// BUSY  | counting down wait cycles; inputs ignored
// DONE  | Ready/Err visible this cycle; returns to IDLE
module dm_bytelane #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE        = 32'h0000_0000,
  parameter int          LATENCY     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] MemAddr,
  input  logic [31:0] MemData,
  input  logic        MemWr,
  input  logic        MemRd,
  input  logic [2:0]  MemOp,
  output logic [31:0] RegData,
  output logic        Ready,
  output logic        Err
);

  localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, nextState;
  logic [2:0]  cnt, cntNext;
  logic        latchReq, doAccess;

  logic [31:0] addrQ, dataQ;
  logic [2:0]  opQ;
  logic        wrQ;

  logic [31:0] mem [DEPTH_WORDS];

  // With LATENCY=0 the access happens at the acceptance edge, so the
  // datapath must see the live inputs while in IDLE.
  logic [31:0] curAddr, curData;
  logic [2:0]  curOp;
  logic        curWr;

  logic [31:0] offset;
  logic [1:0]  lane;
  logic [IW-1:0] wIdx;
  logic        accErr;
  logic [31:0] rdWord, shifted, ldVal, wrMask, wrData, newWord;

  always_comb begin
    if (state == IDLE) begin
      curAddr = MemAddr;
      curData = MemData;
      curOp   = MemOp;
      curWr   = MemWr;
    end else begin
      curAddr = addrQ;
      curData = dataQ;
      curOp   = opQ;
      curWr   = wrQ;
    end
  end

  always_comb begin
    offset  = curAddr - BASE;
    lane    = offset[1:0];
    wIdx    = offset[IW+1:2];
    accErr  = 1'b0;
    if (curAddr < BASE)                                  accErr = 1'b1;
    if ({2'b00, offset[31:2]} >= 32'(DEPTH_WORDS))       accErr = 1'b1;
    if (curOp > 3'd4)                                    accErr = 1'b1;
    if (curOp == 3'd0 && lane != 2'd0)                   accErr = 1'b1;
    if ((curOp == 3'd3 || curOp == 3'd4) && lane[0])     accErr = 1'b1;
  end

  always_comb begin
    rdWord  = mem[wIdx];
    shifted = rdWord >> {lane, 3'b000};
    case (curOp)
      3'd0:    ldVal = rdWord;
      3'd1:    ldVal = {24'h0, shifted[7:0]};
      3'd2:    ldVal = {{24{shifted[7]}}, shifted[7:0]};
      3'd3:    ldVal = {16'h0, shifted[15:0]};
      3'd4:    ldVal = {{16{shifted[15]}}, shifted[15:0]};
      default: ldVal = 32'h0;
    endcase
    case (curOp)
      3'd1, 3'd2: begin
        wrMask = 32'h0000_00FF << {lane, 3'b000};
        wrData = {4{curData[7:0]}};
      end
      3'd3, 3'd4: begin
        wrMask = 32'h0000_FFFF << {lane, 3'b000};
        wrData = {2{curData[15:0]}};
      end
      default: begin
        wrMask = 32'hFFFF_FFFF;
        wrData = curData;
      end
    endcase
    newWord = (rdWord & ~wrMask) | (wrData & wrMask);
  end

  always_comb begin
    nextState = state;
    cntNext   = cnt;
    latchReq  = 1'b0;
    doAccess  = 1'b0;
    case (state)
      IDLE: begin
        if (MemWr || MemRd) begin
          latchReq = 1'b1;
          if (LATENCY == 0) begin
            doAccess  = 1'b1;
            nextState = DONE;
          end else begin
            cntNext   = 3'(LATENCY - 1);
            nextState = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt == 3'd0) begin
          doAccess  = 1'b1;
          nextState = DONE;
        end else begin
          cntNext = cnt - 3'd1;
        end
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= nextState;
      cnt   <= cntNext;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      Ready   <= 1'b0;
      Err     <= 1'b0;
      RegData <= 32'h0;
      addrQ   <= 32'h0;
      dataQ   <= 32'h0;
      opQ     <= 3'd0;
      wrQ     <= 1'b0;
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= 32'h0;
    end else begin
      Ready <= 1'b0;
      Err   <= 1'b0;
      if (latchReq) begin
        addrQ <= MemAddr;
        dataQ <= MemData;
        opQ   <= MemOp;
        wrQ   <= MemWr;
      end
      if (doAccess) begin
        Ready <= 1'b1;
        Err   <= accErr;
        if (accErr)     RegData    <= 32'h0;
        else if (curWr) mem[wIdx]  <= newWord;
        else            RegData    <= ldVal;
      end
    end
  end

endmodule

// File: tb/tb_dm_bytelane.sv
// Testbench for dm_bytelane: three instances (LATENCY 0, 1, 3) with separate
// request inputs and a shared clock/reset. Expected completions are queued
// when a request is driven and compared when Ready appears.
module tb_dm_bytelane;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addrS [3];
  logic [31:0] dataS [3];
  logic        wrS   [3];
  logic        rdS   [3];
  logic [2:0]  opS   [3];
  logic [31:0] regS  [3];
  logic        readyS[3];
  logic        errS  [3];

  int lat [3] = '{0, 1, 3};

  always #5 clk = ~clk;

  dm_bytelane #(.LATENCY(0)) dut0 (
    .clk(clk), .reset(reset), .MemAddr(addrS[0]), .MemData(dataS[0]),
    .MemWr(wrS[0]), .MemRd(rdS[0]), .MemOp(opS[0]),
    .RegData(regS[0]), .Ready(readyS[0]), .Err(errS[0]));
  dm_bytelane #(.LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .MemAddr(addrS[1]), .MemData(dataS[1]),
    .MemWr(wrS[1]), .MemRd(rdS[1]), .MemOp(opS[1]),
    .RegData(regS[1]), .Ready(readyS[1]), .Err(errS[1]));
  dm_bytelane #(.LATENCY(3)) dut2 (
    .clk(clk), .reset(reset), .MemAddr(addrS[2]), .MemData(dataS[2]),
    .MemWr(wrS[2]), .MemRd(rdS[2]), .MemOp(opS[2]),
    .RegData(regS[2]), .Ready(readyS[2]), .Err(errS[2]));

  typedef struct {
    logic [31:0] rd;
    logic        err;
    string       nm;
  } exp_t;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] expRd;
    logic        expErr;
    string       nm;
  } vec_t;

  exp_t sbq[$];
  vec_t tbl[24];
  int   nCmp = 0;
  int   nBad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    nCmp++;
    if (act !== req) begin
      nBad++;
      $display("FAIL %s: got %08h expected %08h", nm, act, req);
    end
  endtask

  task automatic access(input int k, input logic wr, input logic rd, input logic [2:0] op,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic [31:0] expRd, input logic expErr,
                        input string nm, input bit scramble);
    int   cyc;
    bit   seen;
    exp_t e;
    @(negedge clk);
    wrS[k] = wr; rdS[k] = rd; opS[k] = op; addrS[k] = addr; dataS[k] = data;
    sbq.push_back('{expRd, expErr, nm});
    cyc = 0;
    seen = 0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (scramble) begin
        addrS[k] = addr + 32'd4; dataS[k] = ~data; opS[k] = 3'b111;
        wrS[k] = 1'b1; rdS[k] = 1'b1;
      end else begin
        wrS[k] = 1'b0; rdS[k] = 1'b0;
      end
      if (readyS[k]) seen = 1;
    end
    wrS[k] = 1'b0; rdS[k] = 1'b0;
    e = sbq.pop_front();
    if (!seen) begin
      nCmp++; nBad++;
      $display("FAIL %s.timeout: no Ready within %0d cycles", e.nm, cyc);
    end else begin
      check({e.nm, ".data"}, regS[k], e.rd);
      check({e.nm, ".err"}, 32'(errS[k]), 32'(e.err));
      check({e.nm, ".latency"}, 32'(cyc), 32'(lat[k] + 1));
    end
  endtask

  task automatic burst(input int k);
    int last;
    int pulses;
    last = -1;
    pulses = 0;
    @(negedge clk);
    wrS[k] = 1'b1; rdS[k] = 1'b0; opS[k] = 3'd0; addrS[k] = 32'h40; dataS[k] = 32'h1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      addrS[k] = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      dataS[k] = $urandom;
      if (readyS[k]) begin
        if (last >= 0) check($sformatf("burst%0d.interval", k), 32'(c - last), 32'(lat[k] + 2));
        last = c;
        pulses++;
      end
    end
    wrS[k] = 1'b0;
    check($sformatf("burst%0d.enoughPulses", k), 32'(pulses >= 40 / (lat[k] + 2) - 1), 32'd1);
    repeat (6) @(negedge clk);
  endtask

  initial begin
    bit rdySeen;
    for (int k = 0; k < 3; k++) begin
      wrS[k] = 0; rdS[k] = 0; opS[k] = 0; addrS[k] = 0; dataS[k] = 0;
    end

    tbl[0]  = '{1, 0, 3'd0, 32'h0,    32'h12345678, 32'h00000000, 0, "sw@0"};
    tbl[1]  = '{0, 1, 3'd0, 32'h0,    32'h0,        32'h12345678, 0, "lw@0"};
    tbl[2]  = '{1, 0, 3'd1, 32'h5,    32'hFFFFFF80, 32'h12345678, 0, "sb@5"};
    tbl[3]  = '{0, 1, 3'd2, 32'h5,    32'h0,        32'hFFFFFF80, 0, "lb@5"};
    tbl[4]  = '{0, 1, 3'd1, 32'h5,    32'h0,        32'h00000080, 0, "lbu@5"};
    tbl[5]  = '{0, 1, 3'd0, 32'h4,    32'h0,        32'h00008000, 0, "lw@4"};
    tbl[6]  = '{1, 0, 3'd3, 32'h2,    32'h0000BEEF, 32'h00008000, 0, "sh@2"};
    tbl[7]  = '{0, 1, 3'd0, 32'h0,    32'h0,        32'hBEEF5678, 0, "lw@0b"};
    tbl[8]  = '{0, 1, 3'd4, 32'h2,    32'h0,        32'hFFFFBEEF, 0, "lh@2"};
    tbl[9]  = '{0, 1, 3'd3, 32'h2,    32'h0,        32'h0000BEEF, 0, "lhu@2"};
    tbl[10] = '{0, 1, 3'd0, 32'h3,    32'h0,        32'h00000000, 1, "lw@3err"};
    tbl[11] = '{1, 0, 3'd3, 32'h1,    32'h0000DEAD, 32'h00000000, 1, "sh@1err"};
    tbl[12] = '{0, 1, 3'd0, 32'h1000, 32'h0,        32'h00000000, 1, "lwOobErr"};
    tbl[13] = '{0, 1, 3'd7, 32'h0,    32'h0,        32'h00000000, 1, "op7LdErr"};
    tbl[14] = '{1, 0, 3'd7, 32'h4,    32'hFFFFFFFF, 32'h00000000, 1, "op7StErr"};
    tbl[15] = '{0, 1, 3'd0, 32'h0,    32'h0,        32'hBEEF5678, 0, "lw@0c"};
    tbl[16] = '{0, 1, 3'd0, 32'h4,    32'h0,        32'h00008000, 0, "lw@4b"};
    tbl[17] = '{1, 1, 3'd0, 32'hC,    32'hCAFEF00D, 32'h00008000, 0, "wrRdIsStore"};
    tbl[18] = '{0, 1, 3'd0, 32'hC,    32'h0,        32'hCAFEF00D, 0, "lw@C"};
    tbl[19] = '{1, 0, 3'd1, 32'hE,    32'h00000011, 32'hCAFEF00D, 0, "sb@E"};
    tbl[20] = '{0, 1, 3'd2, 32'hF,    32'h0,        32'hFFFFFFCA, 0, "lb@F"};
    tbl[21] = '{0, 1, 3'd3, 32'hE,    32'h0,        32'h0000CA11, 0, "lhu@E"};
    tbl[22] = '{0, 1, 3'd4, 32'hC,    32'h0,        32'hFFFFF00D, 0, "lh@C"};
    tbl[23] = '{0, 1, 3'd1, 32'hC,    32'h0,        32'h0000000D, 0, "lbu@C"};

    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst%0d.ready", k), 32'(readyS[k]), 32'd0);
      check($sformatf("rst%0d.err", k), 32'(errS[k]), 32'd0);
      check($sformatf("rst%0d.regData", k), regS[k], 32'd0);
    end
    reset = 1'b0;

    for (int i = 0; i < 24; i++)
      access(1, tbl[i].wr, tbl[i].rd, tbl[i].op, tbl[i].addr, tbl[i].data,
             tbl[i].expRd, tbl[i].expErr, tbl[i].nm, 0);

    access(2, 1, 0, 3'd0, 32'h10, 32'hA5A5A5A5, 32'h0, 0, "L3.swScrambled", 1);
    access(2, 0, 1, 3'd0, 32'h10, 32'h0, 32'hA5A5A5A5, 0, "L3.lw@10", 0);
    access(2, 0, 1, 3'd0, 32'h14, 32'h0, 32'h00000000, 0, "L3.lw@14", 0);

    access(0, 1, 0, 3'd1, 32'h3, 32'h0000007F, 32'h0, 0, "L0.sb@3", 0);
    access(0, 0, 1, 3'd1, 32'h3, 32'h0, 32'h0000007F, 0, "L0.lbu@3", 0);
    access(0, 0, 1, 3'd0, 32'h0, 32'h0, 32'h7F000000, 0, "L0.lw@0", 0);

    burst(0);
    burst(2);

    // Reset during BUSY of a store must abort it
    @(negedge clk);
    wrS[1] = 1'b1; opS[1] = 3'd0; addrS[1] = 32'h8; dataS[1] = 32'hAAAAAAAA;
    @(negedge clk);
    wrS[1] = 1'b0;
    reset = 1'b1;
    rdySeen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      reset = 1'b0;
      if (readyS[1]) rdySeen = 1;
    end
    check("rstBusy.noReady", 32'(rdySeen), 32'd0);
    access(1, 0, 1, 3'd0, 32'h8, 32'h0, 32'h00000000, 0, "rstBusy.lw@8", 0);
    access(1, 0, 1, 3'd0, 32'h0, 32'h0, 32'h00000000, 0, "rstCleared.lw@0", 0);

    // Reset wins over a request sampled on the same edge
    @(negedge clk);
    reset = 1'b1;
    wrS[1] = 1'b1; opS[1] = 3'd0; addrS[1] = 32'h10; dataS[1] = 32'h12345678;
    @(negedge clk);
    reset = 1'b0;
    wrS[1] = 1'b0;
    rdySeen = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (readyS[1]) rdySeen = 1;
    end
    check("rstPrio.noReady", 32'(rdySeen), 32'd0);
    access(1, 0, 1, 3'd0, 32'h10, 32'h0, 32'h00000000, 0, "rstPrio.lw@10", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
